// File: rtl/exhaustive_stim_sequencer.sv
// Exhaustive stimulus sequencer: sweeps every WIDTH-bit pattern, captures a 1-bit response.
// Optional macro STIM_SIGNATURE_EN adds a 16-bit CRC-style response signature on port sig.
`timescale 1ns/1ps
module exhaustive_stim_sequencer #(
  parameter int WIDTH  = 8,
  parameter int SETTLE = 1
) (
  input  logic             CK,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  output logic [WIDTH-1:0] dut_in,
  input  logic             dut_out,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [WIDTH-1:0] rec_pattern,
  output logic             rec_bit,
  output logic             busy,
  output logic             done,
  output logic             aborted
`ifdef STIM_SIGNATURE_EN
  ,
  output logic [15:0]      sig
`endif
);

  typedef enum logic [2:0] {
    IDLE, APPLY, WAIT, SAMPLE, EMIT, FIN
  } state_t;

  localparam logic [WIDTH-1:0] LAST = '1;
  localparam logic [3:0]       SET  = 4'(SETTLE);

  state_t           state;
  logic [WIDTH-1:0] cnt;
  logic [3:0]       settle;
  logic             kill;

  // Abort is honoured in every active state; FIN is already ending.
  assign kill = abort && (state != IDLE) && (state != FIN);

  always_ff @(posedge CK or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      settle      <= '0;
      dut_in      <= '0;
      rec_pattern <= '0;
      rec_bit     <= 1'b0;
      rec_valid   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      aborted     <= 1'b0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      if (kill) begin
        state     <= FIN;
        rec_valid <= 1'b0;
        done      <= 1'b1;
        aborted   <= 1'b1;
      end else begin
        unique case (state)
          IDLE: begin
            if (start) begin
              cnt    <= '0;
              dut_in <= '0;
              busy   <= 1'b1;
              state  <= APPLY;
            end
          end
          APPLY: begin
            settle <= SET;
            state  <= (SETTLE == 0) ? SAMPLE : WAIT;
          end
          WAIT: begin
            settle <= settle - 4'd1;
            if (settle <= 4'd1) state <= SAMPLE;
          end
          SAMPLE: begin
            rec_bit     <= dut_out;
            rec_pattern <= cnt;
            rec_valid   <= 1'b1;
            state       <= EMIT;
          end
          EMIT: begin
            if (rec_ready) begin
              rec_valid <= 1'b0;
              if (cnt == LAST) begin
                state <= FIN;
                done  <= 1'b1;
              end else begin
                cnt    <= cnt + 1'b1;
                dut_in <= cnt + 1'b1;
                state  <= APPLY;
              end
            end
          end
          FIN: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef STIM_SIGNATURE_EN
  logic xfer;
  assign xfer = (state == EMIT) && rec_ready && !abort;

  always_ff @(posedge CK or posedge reset) begin
    if (reset) begin
      sig <= 16'hFFFF;
    end else if (state == IDLE && start) begin
      sig <= 16'hFFFF;
    end else if (xfer) begin
      sig <= {sig[14:0], 1'b0}
           ^ ((sig[15] ^ rec_bit) ? 16'h1021 : 16'h0000);
    end
  end
`endif

endmodule
